// File: rtl/sweeper_pkg.sv
// Shared types and helpers for the exhaustive stimulus sweeper and its MISR.
package sweeper_pkg;

    localparam int unsigned MISR_MAX_W = 32;
    localparam int unsigned STIM_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Binary to reflected Gray code.
    function automatic logic [STIM_MAX_W-1:0] gray(input logic [STIM_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // One MISR shift of a w-bit register held in the low bits of a 32-bit word.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] poly,
        input logic [MISR_MAX_W-1:0] din,
        input int unsigned           w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        logic                  msb;
        mask = (w >= MISR_MAX_W) ? '1 : ((32'd1 << w) - 32'd1);
        msb  = sig[5'(w - 32'd1)];
        nxt  = (sig << 1) ^ (msb ? poly : 32'd0) ^ din;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// Signature register: folds an M-bit response into a SIG_W-bit MISR.
module misr_reg
    import sweeper_pkg::*;
#(
    parameter int unsigned     SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter int unsigned     M     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [M-1:0]     din,
    output logic [SIG_W-1:0] q
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = SIG_W'(misr_step(32'(sig_q), 32'(POLY), 32'(din), SIG_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign q = sig_q;

endmodule

// File: rtl/exhaustive_sweeper.sv
// Walks all 2^N stimulus vectors (binary or Gray order), holding each STEP
// cycles, and compresses the block-under-test response into a MISR signature.
module exhaustive_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned      N     = 5,
    parameter int unsigned      M     = 3,
    parameter int unsigned      STEP  = 1,
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [M-1:0]     resp,
    output logic [N-1:0]     stim,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [N:0]       vec_count
);

    localparam int unsigned    HOLD_W    = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(STEP - 1);
    localparam logic [N-1:0]   LAST_IDX  = '1;

    generate
        if (STEP < 1 || M < 1 || M > SIG_W || N < 1 || N > STIM_MAX_W ||
            SIG_W > MISR_MAX_W) begin : gen_param_check
            $error("exhaustive_sweeper: illegal parameter combination");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [N-1:0]        index_q, index_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                mode_q, mode_d;
    logic [N-1:0]        stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N:0]          vec_count_q, vec_count_d;
    logic                misr_clr;
    logic                misr_en;

    function automatic logic [N-1:0] vector_of(input logic [N-1:0] k, input logic g);
        return g ? N'(gray(STIM_MAX_W'(k))) : k;
    endfunction

    // Next-state, counters and handshake outputs.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        hold_d      = hold_q;
        mode_d      = mode_q;
        stim_d      = stim_q;
        busy_d      = busy_q;
        done_d      = done_q;
        vec_count_d = vec_count_q;
        misr_clr    = 1'b0;
        misr_en     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    index_d     = '0;
                    hold_d      = '0;
                    mode_d      = mode;
                    stim_d      = vector_of('0, mode);
                    vec_count_d = '0;
                    misr_clr    = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    // Partial signature and count are kept for debug.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    stim_d  = '0;
                end else if (hold_q == LAST_HOLD) begin
                    misr_en     = 1'b1;
                    vec_count_d = vec_count_q + (N+1)'(1);
                    if (index_q != LAST_IDX) begin
                        index_d = index_q + N'(1);
                        hold_d  = '0;
                        stim_d  = vector_of(index_q + N'(1), mode_q);
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            index_q     <= '0;
            hold_q      <= '0;
            mode_q      <= 1'b0;
            stim_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            hold_q      <= hold_d;
            mode_q      <= mode_d;
            stim_q      <= stim_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vec_count_q <= vec_count_d;
        end
    end

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .M     (M)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .din   (resp),
        .q     (signature)
    );

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_exhaustive_sweeper.sv
// Self-checking bench: three sweeper configurations against a behavioural
// truth-table/MISR model with randomized response tables, modes and aborts.
module tb_exhaustive_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Config A: N=2, M=1, STEP=1, SIG_W=4, POLY=3, resp = parity(stim)
    logic       a_start, a_abort, a_mode;
    logic [0:0] a_resp;
    logic [1:0] a_stim;
    logic       a_busy, a_done;
    logic [3:0] a_sig;
    logic [2:0] a_cnt;
    assign a_resp = ^a_stim;

    // Config B: as A with STEP=3
    logic       b_start, b_abort, b_mode;
    logic [0:0] b_resp;
    logic [1:0] b_stim;
    logic       b_busy, b_done;
    logic [3:0] b_sig;
    logic [2:0] b_cnt;
    assign b_resp = ^b_stim;

    // Config C: defaults, resp from a random truth table
    logic        c_start, c_abort, c_mode;
    logic [2:0]  c_resp;
    logic [4:0]  c_stim;
    logic        c_busy, c_done;
    logic [15:0] c_sig;
    logic [5:0]  c_cnt;
    logic [2:0]  tt [32];
    assign c_resp = tt[c_stim];

    exhaustive_sweeper #(.N(2), .M(1), .STEP(1), .SIG_W(4), .POLY(4'h3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .mode(a_mode),
        .resp(a_resp), .stim(a_stim), .busy(a_busy), .done(a_done),
        .signature(a_sig), .vec_count(a_cnt)
    );

    exhaustive_sweeper #(.N(2), .M(1), .STEP(3), .SIG_W(4), .POLY(4'h3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .mode(b_mode),
        .resp(b_resp), .stim(b_stim), .busy(b_busy), .done(b_done),
        .signature(b_sig), .vec_count(b_cnt)
    );

    exhaustive_sweeper dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .mode(c_mode),
        .resp(c_resp), .stim(c_stim), .busy(c_busy), .done(c_done),
        .signature(c_sig), .vec_count(c_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int vec_of(input int k, input bit g);
        return g ? (k ^ (k >> 1)) : k;
    endfunction

    // Signature after the first 'samples' vectors of a sweep.
    function automatic int model_sig(input int w, input int poly, input bit g,
                                     input int samples, input bit use_tt);
        int sig = 0;
        for (int k = 0; k < samples; k++) begin
            int v   = vec_of(k, g);
            int r   = use_tt ? int'(tt[v]) : ($countones(v) % 2);
            int top = sig / (1 << (w - 1));
            sig = ((sig * 2) % (1 << w)) ^ (top != 0 ? poly : 0) ^ r;
        end
        return sig;
    endfunction

    task automatic run_a(input bit g, input int golden);
        @(negedge clk);
        a_start = 1'b1;
        a_mode  = g;
        @(negedge clk);
        a_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("a_stim", 64'(a_stim), 64'(vec_of(k, g)));
            check("a_busy", 64'(a_busy), 64'(1));
            check("a_done_run", 64'(a_done), 64'(0));
            a_mode = 1'($urandom);
            @(negedge clk);
        end
        check("a_busy_end", 64'(a_busy), 64'(0));
        check("a_done_end", 64'(a_done), 64'(1));
        check("a_cnt_end", 64'(a_cnt), 64'(4));
        check("a_sig_model", 64'(a_sig), 64'(model_sig(4, 3, g, 4, 1'b0)));
        check("a_sig_golden", 64'(a_sig), 64'(golden));
    endtask

    task automatic run_b();
        @(negedge clk);
        b_start = 1'b1;
        b_mode  = 1'b0;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int h = 0; h < 3; h++) begin
                check("b_stim", 64'(b_stim), 64'(k));
                check("b_busy", 64'(b_busy), 64'(1));
                b_mode = 1'($urandom);
                @(negedge clk);
            end
        end
        check("b_busy_end", 64'(b_busy), 64'(0));
        check("b_done_end", 64'(b_done), 64'(1));
        check("b_cnt_end", 64'(b_cnt), 64'(4));
        check("b_sig", 64'(b_sig), 64'(6));
    endtask

    task automatic run_c(input int abort_s, input bit g);
        int exp_sig;
        @(negedge clk);
        c_start = 1'b1;
        c_mode  = g;
        @(negedge clk);
        c_start = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (j == abort_s) begin
                c_abort = 1'b1;
                c_start = 1'($urandom);
                @(negedge clk);
                c_abort = 1'b0;
                c_start = 1'b0;
                check("c_abort_busy", 64'(c_busy), 64'(0));
                check("c_abort_done", 64'(c_done), 64'(0));
                check("c_abort_stim", 64'(c_stim), 64'(0));
                check("c_abort_cnt", 64'(c_cnt), 64'(j));
                check("c_abort_sig", 64'(c_sig), 64'(model_sig(16, 'h1021, g, j, 1'b1)));
                return;
            end
            check("c_stim", 64'(c_stim), 64'(vec_of(j, g)));
            check("c_busy", 64'(c_busy), 64'(1));
            check("c_cnt", 64'(c_cnt), 64'(j));
            c_mode  = 1'($urandom);
            c_start = 1'($urandom);
            @(negedge clk);
        end
        c_start = 1'b0;
        exp_sig = model_sig(16, 'h1021, g, 32, 1'b1);
        check("c_busy_end", 64'(c_busy), 64'(0));
        check("c_done_end", 64'(c_done), 64'(1));
        check("c_cnt_end", 64'(c_cnt), 64'(32));
        check("c_stim_end", 64'(c_stim), 64'(vec_of(31, g)));
        check("c_sig_end", 64'(c_sig), 64'(exp_sig));
        repeat (2) @(negedge clk);
        check("c_done_hold", 64'(c_done), 64'(1));
        check("c_sig_hold", 64'(c_sig), 64'(exp_sig));
    endtask

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_mode = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_mode = 1'b0;
        c_start = 1'b0; c_abort = 1'b0; c_mode = 1'b0;
        foreach (tt[i]) tt[i] = 3'($urandom);
        repeat (2) @(negedge clk);

        check("rst_a_stim", 64'(a_stim), 64'(0));
        check("rst_a_busy", 64'(a_busy), 64'(0));
        check("rst_a_done", 64'(a_done), 64'(0));
        check("rst_a_sig", 64'(a_sig), 64'(0));
        check("rst_a_cnt", 64'(a_cnt), 64'(0));
        check("rst_c_stim", 64'(c_stim), 64'(0));
        check("rst_c_sig", 64'(c_sig), 64'(0));
        check("rst_c_cnt", 64'(c_cnt), 64'(0));
        rst_n = 1'b1;

        run_a(1'b0, 6);
        run_a(1'b1, 5);
        run_b();

        // Abort after two samples, with start held high throughout.
        @(negedge clk);
        a_start = 1'b1;
        a_mode  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("a_pre_abort_cnt", 64'(a_cnt), 64'(2));
        check("a_pre_abort_busy", 64'(a_busy), 64'(1));
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        a_start = 1'b0;
        check("a_abort_busy", 64'(a_busy), 64'(0));
        check("a_abort_done", 64'(a_done), 64'(0));
        check("a_abort_stim", 64'(a_stim), 64'(0));
        check("a_abort_cnt", 64'(a_cnt), 64'(2));
        check("a_abort_sig", 64'(a_sig), 64'(1));
        run_a(1'b0, 6);

        // Reset in the middle of a default-config sweep.
        @(negedge clk);
        c_start = 1'b1;
        c_mode  = 1'b0;
        @(negedge clk);
        c_start = 1'b0;
        @(negedge clk);
        check("c_mid_cnt", 64'(c_cnt), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("c_rst_stim", 64'(c_stim), 64'(0));
        check("c_rst_busy", 64'(c_busy), 64'(0));
        check("c_rst_done", 64'(c_done), 64'(0));
        check("c_rst_sig", 64'(c_sig), 64'(0));
        check("c_rst_cnt", 64'(c_cnt), 64'(0));
        run_c(99, 1'b0);

        repeat (10) begin
            int s;
            foreach (tt[i]) tt[i] = 3'($urandom);
            s = int'($urandom_range(1, 40));
            run_c((s >= 32) ? 99 : s, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
